tempdivq_arb: RTL and testbench

Arbiter and clear sequencer for the TempdivQ distributed RAM (2048 × 13-bit, synchronous write, asynchronous read) in the SNTRUP757 division datapath. Two write requesters and two read requesters share the single RAM write port and the single read port through round-robin arbitration. A built-in clear sequencer zeroes the first CLEAR_LEN coefficients before each division pass. The block sits between the division/loader units and the TempdivQ RAM instance and drives all RAM ports.

---
 rtl/tempdivq_pkg.sv | 14 +
 rtl/tempdivq_arb_rr_arb2.sv | 28 ++
 rtl/tempdivq_arb.sv | 141 ++++++++++++++
 tb/tb_tempdivq_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tempdivq_pkg.sv
// Shared constants and state encoding for the TempdivQ RAM arbiter.
// Imported by the arbiter top level and its testbench.
package tempdivq_pkg;

    localparam int RAM_WIDTH     = 13;
    localparam int RAM_ADDR_BITS = 11;
    localparam int CLEAR_LEN     = 757;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/tempdivq_arb_rr_arb2.sv
// Two-input round-robin arbiter with a single priority pointer.
// The pointer only moves when both inputs contend and a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    // Lone requester wins outright; contention is settled by the pointer.
    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
    end

    // Hand priority to the loser after every contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/tempdivq_arb.sv
// TempdivQ RAM port arbiter: two writers and two readers share one
// write and one read port; a clear sequencer zeroes the low entries.
module tempdivq_arb #(
    parameter int RAM_WIDTH     = tempdivq_pkg::RAM_WIDTH,
    parameter int RAM_ADDR_BITS = tempdivq_pkg::RAM_ADDR_BITS,
    parameter int CLEAR_LEN     = tempdivq_pkg::CLEAR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    input  logic                     wr0_valid,
    output logic                     wr0_ready,
    input  logic [RAM_ADDR_BITS-1:0] wr0_addr,
    input  logic [RAM_WIDTH-1:0]     wr0_data,
    input  logic                     wr1_valid,
    output logic                     wr1_ready,
    input  logic [RAM_ADDR_BITS-1:0] wr1_addr,
    input  logic [RAM_WIDTH-1:0]     wr1_data,
    input  logic                     rd0_valid,
    output logic                     rd0_ready,
    input  logic [RAM_ADDR_BITS-1:0] rd0_addr,
    output logic                     rd0_rvalid,
    output logic [RAM_WIDTH-1:0]     rd0_rdata,
    input  logic                     rd1_valid,
    output logic                     rd1_ready,
    input  logic [RAM_ADDR_BITS-1:0] rd1_addr,
    output logic                     rd1_rvalid,
    output logic [RAM_WIDTH-1:0]     rd1_rdata,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_waddr,
    output logic [RAM_ADDR_BITS-1:0] ram_raddr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);

    import tempdivq_pkg::*;

    localparam logic [RAM_ADDR_BITS-1:0] LAST =
        RAM_ADDR_BITS'(CLEAR_LEN - 1);

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] cnt;
    logic                     idle;
    logic [1:0]               wv;
    logic [1:0]               rv;
    logic [1:0]               wg;
    logic [1:0]               rg;

    // Arbitration is only live outside clear and outside reset.
    assign idle = (state == IDLE) && !rst;
    assign wv   = {wr1_valid, wr0_valid} & {2{idle}};
    assign rv   = {rd1_valid, rd0_valid} & {2{idle}};

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (wv),
        .advance (&wv),
        .grant   (wg)
    );

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (rv),
        .advance (&rv),
        .grant   (rg)
    );

    assign wr0_ready  = wg[0];
    assign wr1_ready  = wg[1];
    assign rd0_ready  = rg[0];
    assign rd1_ready  = rg[1];
    assign clear_busy = (state == CLEAR);

    // Clear sequencer: walk addresses 0..CLEAR_LEN-1, then pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // RAM port muxes: clear owns the write port, otherwise the grant does.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (!rst) begin
            ram_raddr = rg[1] ? rd1_addr : rd0_addr;
            if (state == CLEAR) begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
            end else begin
                ram_we    = |wg;
                ram_waddr = wg[1] ? wr1_addr : wr0_addr;
                ram_wdata = wg[1] ? wr1_data : wr0_data;
            end
        end
    end

    // Capture read data at the handshake edge and hold until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_rvalid <= 1'b0;
            rd1_rvalid <= 1'b0;
            rd0_rdata  <= '0;
            rd1_rdata  <= '0;
        end else begin
            rd0_rvalid <= rg[0];
            rd1_rvalid <= rg[1];
            if (rg[0])
                rd0_rdata <= ram_rdata;
            if (rg[1])
                rd1_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_tempdivq_arb.sv
// Self-checking bench for tempdivq_arb with a behavioural RAM and
// a queue-level reference model of the two round-robin arbiters.
module tb_tempdivq_arb;

    localparam int AW = 11;
    localparam int W  = 13;
    localparam int CL = 757;
    localparam int NE = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic          wr0_valid = 1'b0, wr1_valid = 1'b0;
    logic          wr0_ready, wr1_ready;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
    logic [W-1:0]  wr0_data = '0, wr1_data = '0;
    logic          rd0_valid = 1'b0, rd1_valid = 1'b0;
    logic          rd0_ready, rd1_ready;
    logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
    logic          rd0_rvalid, rd1_rvalid;
    logic [W-1:0]  rd0_rdata, rd1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [W-1:0]  ram_wdata, ram_rdata;

    logic [W-1:0]  mem [NE];
    logic [W-1:0]  ref_mem [NE];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = mem[ram_raddr];

    tempdivq_arb dut (
        .clk(clk), .rst(rst),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready),
        .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready),
        .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_valid(rd0_valid), .rd0_ready(rd0_ready),
        .rd0_addr(rd0_addr), .rd0_rvalid(rd0_rvalid),
        .rd0_rdata(rd0_rdata),
        .rd1_valid(rd1_valid), .rd1_ready(rd1_ready),
        .rd1_addr(rd1_addr), .rd1_rvalid(rd1_rvalid),
        .rd1_rdata(rd1_rdata),
        .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic [1:0] wv;
        logic [1:0] rv;
        logic [1:0] eg_w;
        logic [1:0] eg_r;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        clear_start = 1'b0;
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        rd0_valid = 1'b0; rd1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wr_one(input int a, input int d);
        wr0_valid = 1'b1; wr0_addr = AW'(a); wr0_data = W'(d);
        @(posedge clk); #1;
        wr0_valid = 1'b0;
    endtask

    task automatic rd_one(input int a, output logic [W-1:0] d);
        rd0_valid = 1'b1; rd0_addr = AW'(a);
        @(posedge clk); #1;
        rd0_valid = 1'b0;
        d = rd0_rdata;
    endtask

    task automatic preload();
        wr0_valid = 1'b1; wr0_data = 13'h1FFF;
        for (int i = 0; i < NE; i++) begin
            wr0_addr = AW'(i);
            @(posedge clk); #1;
        end
        wr0_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]    prev_rg;
        logic [W-1:0]  d;
        int            bad, busy_cnt, first_busy, last_busy;
        int            done_cnt, done_n, ready_n;
        logic          p_w [2];
        logic          p_r [2];
        logic [AW-1:0] pw_a [2];
        logic [W-1:0]  pw_d [2];
        logic [AW-1:0] pr_a [2];
        logic          exp_rv [2];
        logic [W-1:0]  exp_rd [2];
        int            gw, gr, last_w, last_r;

        tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 2'b10, 2'b01, 2'b10};
        tbl[2] = '{2'b11, 2'b11, 2'b01, 2'b01};
        tbl[3] = '{2'b11, 2'b11, 2'b10, 2'b10};
        tbl[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        tbl[5] = '{2'b11, 2'b11, 2'b01, 2'b01};
        tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b01};
        tbl[7] = '{2'b11, 2'b11, 2'b10, 2'b10};

        // Reset state, with every request input asserted.
        clear_start = 1'b1;
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        rd0_valid = 1'b1; rd1_valid = 1'b1;
        wr0_addr = 11'h3; wr0_data = 13'h55;
        rd0_addr = 11'h7;
        @(negedge clk);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_wrdy", 32'({wr1_ready, wr0_ready}), 0);
        chk("rst_rrdy", 32'({rd1_ready, rd0_ready}), 0);
        chk("rst_rvalid", 32'({rd1_rvalid, rd0_rvalid}), 0);
        chk("rst_rdata0", 32'(rd0_rdata), 0);
        chk("rst_rdata1", 32'(rd1_rdata), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_raddr", 32'(ram_raddr), 0);
        idle_in();
        @(posedge clk); #1 rst = 1'b0;

        // Table: single-cycle arbitration patterns from a fresh pointer.
        prev_rg = 2'b00;
        for (int i = 0; i < 8; i++) begin
            wr0_valid = tbl[i].wv[0]; wr1_valid = tbl[i].wv[1];
            rd0_valid = tbl[i].rv[0]; rd1_valid = tbl[i].rv[1];
            wr0_addr = AW'(100 + i); wr1_addr = AW'(200 + i);
            wr0_data = W'(i); wr1_data = W'(16 + i);
            rd0_addr = AW'(i); rd1_addr = AW'(8 + i);
            @(negedge clk);
            chk("tbl_wgnt", 32'({wr1_ready, wr0_ready}), 32'(tbl[i].eg_w));
            chk("tbl_rgnt", 32'({rd1_ready, rd0_ready}), 32'(tbl[i].eg_r));
            chk("tbl_we", 32'(ram_we), 32'(|tbl[i].eg_w));
            if (tbl[i].eg_w != 2'b00)
                chk("tbl_waddr", 32'(ram_waddr),
                    tbl[i].eg_w[1] ? 200 + i : 100 + i);
            chk("tbl_rvalid", 32'({rd1_rvalid, rd0_rvalid}), 32'(prev_rg));
            prev_rg = tbl[i].eg_r;
            @(posedge clk); #1;
        end
        idle_in();
        @(negedge clk);
        chk("tbl_rvalid_last", 32'({rd1_rvalid, rd0_rvalid}), 32'(prev_rg));
        @(posedge clk); #1;

        // Reset in the middle of a clear.
        preload();
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_busy_before", 32'(clear_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_busy_rst", 32'(clear_busy), 0);
        chk("mid_we_rst", 32'(ram_we), 0);
        @(posedge clk); #1 rst = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
        end
        chk("mid_no_busy", 32'(busy_cnt), 0);
        chk("mid_no_done", 32'(done_cnt), 0);
        bad = 0;
        for (int i = 0; i < 99; i++) if (mem[i] !== '0) bad++;
        chk("mid_low_zero", 32'(bad), 0);
        bad = 0;
        for (int i = 100; i < NE; i++) if (mem[i] !== 13'h1FFF) bad++;
        chk("mid_high_kept", 32'(bad), 0);
        @(posedge clk); #1;

        // Full clear with a write request waiting throughout.
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        wr0_valid = 1'b1; wr0_addr = 11'd800; wr0_data = 13'h111;
        busy_cnt = 0; first_busy = 0; last_busy = 0;
        done_cnt = 0; done_n = 0; ready_n = 0;
        for (int n = 1; n <= 760; n++) begin
            @(negedge clk);
            if (clear_busy) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = n;
                last_busy = n;
            end
            if (clear_done) begin
                done_cnt++;
                done_n = n;
            end
            if (wr0_ready) begin
                if (ready_n == 0) ready_n = n;
                @(posedge clk); #1 wr0_valid = 1'b0;
            end
        end
        chk("clr_busy_cnt", 32'(busy_cnt), CL);
        chk("clr_busy_first", 32'(first_busy), 1);
        chk("clr_busy_last", 32'(last_busy), CL);
        chk("clr_done_cnt", 32'(done_cnt), 1);
        chk("clr_done_cycle", 32'(done_n), CL + 1);
        chk("clr_wr_ready_cycle", 32'(ready_n), CL + 1);
        bad = 0;
        for (int i = 0; i < CL; i++) if (mem[i] !== '0) bad++;
        chk("clr_zeroed", 32'(bad), 0);
        chk("clr_edge_kept", 32'(mem[CL]), 32'h1FFF);
        chk("clr_pending_wr", 32'(mem[800]), 32'h111);
        @(posedge clk); #1;

        // Write contention: both sides valid with two writes each.
        do_reset();
        begin
            logic [AW-1:0] qa0 [2];
            logic [AW-1:0] qa1 [2];
            int            k0, k1;
            logic [1:0]    exp_g [4];
            qa0[0] = 11'd300; qa0[1] = 11'd301;
            qa1[0] = 11'd310; qa1[1] = 11'd311;
            exp_g[0] = 2'b01; exp_g[1] = 2'b10;
            exp_g[2] = 2'b01; exp_g[3] = 2'b10;
            k0 = 0; k1 = 0;
            for (int c = 0; c < 4; c++) begin
                wr0_valid = 1'b1; wr1_valid = 1'b1;
                wr0_addr = qa0[k0]; wr0_data = W'(12'hA00 + k0);
                wr1_addr = qa1[k1]; wr1_data = W'(12'hB00 + k1);
                @(negedge clk);
                chk("wc_grant", 32'({wr1_ready, wr0_ready}), 32'(exp_g[c]));
                if (wr0_ready && k0 < 1) k0++;
                else if (wr1_ready && k1 < 1) k1++;
                @(posedge clk); #1;
            end
            idle_in();
            chk("wc_land0", 32'(mem[300]), 32'hA00);
            chk("wc_land1", 32'(mem[310]), 32'hB00);
            chk("wc_land2", 32'(mem[301]), 32'hA01);
            chk("wc_land3", 32'(mem[311]), 32'hB01);
        end

        // Read contention on addresses 5 and 6.
        wr_one(5, 13'h0AA);
        wr_one(6, 13'h155);
        wr_one(9, 13'h077);
        do_reset();
        rd0_valid = 1'b1; rd0_addr = 11'd5;
        rd1_valid = 1'b1; rd1_addr = 11'd6;
        @(negedge clk);
        chk("rc_grant0", 32'({rd1_ready, rd0_ready}), 32'b01);
        @(posedge clk); #1 rd0_valid = 1'b0;
        @(negedge clk);
        chk("rc_rvalid0", 32'({rd1_rvalid, rd0_rvalid}), 32'b01);
        chk("rc_rdata0", 32'(rd0_rdata), 32'h0AA);
        chk("rc_grant1", 32'({rd1_ready, rd0_ready}), 32'b10);
        @(posedge clk); #1 rd1_valid = 1'b0;
        @(negedge clk);
        chk("rc_rvalid1", 32'({rd1_rvalid, rd0_rvalid}), 32'b10);
        chk("rc_rdata1", 32'(rd1_rdata), 32'h155);
        chk("rc_hold0", 32'(rd0_rdata), 32'h0AA);
        @(posedge clk); #1;

        // Same-cycle read and write of address 9.
        wr0_valid = 1'b1; wr0_addr = 11'd9; wr0_data = 13'h123;
        rd0_valid = 1'b1; rd0_addr = 11'd9;
        @(posedge clk); #1;
        idle_in();
        chk("col_rvalid", 32'(rd0_rvalid), 1);
        chk("col_old", 32'(rd0_rdata), 32'h077);
        rd_one(9, d);
        chk("col_new", 32'(d), 32'h123);

        // Randomised traffic against the reference model.
        do_reset();
        for (int i = 0; i < NE; i++) ref_mem[i] = mem[i];
        p_w[0] = 0; p_w[1] = 0; p_r[0] = 0; p_r[1] = 0;
        exp_rv[0] = 0; exp_rv[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_w = 1; last_r = 1;
        for (int it = 0; it < 400; it++) begin
            for (int s = 0; s < 2; s++) begin
                if (!p_w[s] && $urandom_range(0, 1) == 1) begin
                    p_w[s] = 1;
                    pw_a[s] = AW'($urandom_range(0, 31));
                    pw_d[s] = W'($urandom);
                end
                if (!p_r[s] && $urandom_range(0, 1) == 1) begin
                    p_r[s] = 1;
                    pr_a[s] = AW'($urandom_range(0, 31));
                end
            end
            wr0_valid = p_w[0]; wr0_addr = pw_a[0]; wr0_data = pw_d[0];
            wr1_valid = p_w[1]; wr1_addr = pw_a[1]; wr1_data = pw_d[1];
            rd0_valid = p_r[0]; rd0_addr = pr_a[0];
            rd1_valid = p_r[1]; rd1_addr = pr_a[1];
            gw = -1; gr = -1;
            if (p_w[0] && p_w[1]) gw = 1 - last_w;
            else if (p_w[0]) gw = 0;
            else if (p_w[1]) gw = 1;
            if (p_r[0] && p_r[1]) gr = 1 - last_r;
            else if (p_r[0]) gr = 0;
            else if (p_r[1]) gr = 1;
            @(negedge clk);
            chk("rnd_wr0_ready", 32'(wr0_ready), 32'(gw == 0));
            chk("rnd_wr1_ready", 32'(wr1_ready), 32'(gw == 1));
            chk("rnd_rd0_ready", 32'(rd0_ready), 32'(gr == 0));
            chk("rnd_rd1_ready", 32'(rd1_ready), 32'(gr == 1));
            chk("rnd_we", 32'(ram_we), 32'(gw >= 0));
            chk("rnd_rvalid0", 32'(rd0_rvalid), 32'(exp_rv[0]));
            chk("rnd_rvalid1", 32'(rd1_rvalid), 32'(exp_rv[1]));
            chk("rnd_rdata0", 32'(rd0_rdata), 32'(exp_rd[0]));
            chk("rnd_rdata1", 32'(rd1_rdata), 32'(exp_rd[1]));
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (gr >= 0) begin
                exp_rv[gr] = 1;
                exp_rd[gr] = ref_mem[pr_a[gr]];
                if (p_r[0] && p_r[1]) last_r = gr;
                p_r[gr] = 0;
            end
            if (gw >= 0) begin
                ref_mem[pw_a[gw]] = pw_d[gw];
                if (p_w[0] && p_w[1]) last_w = gw;
                p_w[gw] = 0;
            end
            @(posedge clk); #1;
        end
        idle_in();
        @(negedge clk);
        chk("rnd_rvalid0_end", 32'(rd0_rvalid), 32'(exp_rv[0]));
        chk("rnd_rvalid1_end", 32'(rd1_rvalid), 32'(exp_rv[1]));
        chk("rnd_rdata0_end", 32'(rd0_rdata), 32'(exp_rd[0]));
        chk("rnd_rdata1_end", 32'(rd1_rdata), 32'(exp_rd[1]));
        for (int i = 0; i < 32; i++)
            chk("rnd_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
